// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator.
// Walks a horizontal/vertical counter pair across the full raster and emits
// registered sync, blanking, coordinate and line/frame strobe signals. The
// outputs describe the counter position from before each enabled edge, so
// they lag the counters by one pixel.
//
// Ports:
//   pixel_clock_int  pixel clock, all logic on its rising edge
//   reset            asynchronous active-high reset
//   enable           pixel advance qualifier
//   horiz_sync_out   horizontal sync, active level H_SYNC_POL
//   vert_sync_out    vertical sync, active level V_SYNC_POL
//   video_on         high inside the visible area
//   pixel_column     current column inside the visible area, else 0
//   pixel_row        current row inside the visible area, else 0
//   line_start       one enabled-cycle pulse at column 0 of every line
//   frame_start      one enabled-cycle pulse at pixel (0,0)
//   vblank           high on lines V_ACTIVE..V_TOTAL-1
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = 10
) (
  input  logic             pixel_clock_int,
  input  logic             reset,
  input  logic             enable,
  output logic             horiz_sync_out,
  output logic             vert_sync_out,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_column,
  output logic [CNT_W-1:0] pixel_row,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  // Inclusive sync windows; the end value never exceeds TOTAL-1 so it fits CNT_W.
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic h_last_c;
  logic v_last_c;
  logic hsync_c;
  logic vsync_c;
  logic h_vis_c;
  logic v_vis_c;
  logic h_zero_c;
  logic v_zero_c;

  // Position decode from the current counter values.
  always_comb begin
    h_last_c = (h_cnt == CNT_W'(H_TOTAL - 1));
    v_last_c = (v_cnt == CNT_W'(V_TOTAL - 1));
    hsync_c  = (h_cnt >= CNT_W'(HS_START)) && (h_cnt <= CNT_W'(HS_END));
    vsync_c  = (v_cnt >= CNT_W'(VS_START)) && (v_cnt <= CNT_W'(VS_END));
    h_vis_c  = (h_cnt < CNT_W'(H_ACTIVE));
    v_vis_c  = (v_cnt < CNT_W'(V_ACTIVE));
    h_zero_c = (h_cnt == '0);
    v_zero_c = (v_cnt == '0);
  end

  // Raster counters; the vertical counter steps only as the line wraps.
  always_ff @(posedge pixel_clock_int or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (enable) begin
      if (h_last_c) begin
        h_cnt <= '0;
        v_cnt <= v_last_c ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Registered outputs; levels hold while enable is low, strobes drop to 0.
  always_ff @(posedge pixel_clock_int or posedge reset) begin
    if (reset) begin
      horiz_sync_out <= ~H_SYNC_POL;
      vert_sync_out  <= ~V_SYNC_POL;
      video_on       <= 1'b0;
      pixel_column   <= '0;
      pixel_row      <= '0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      vblank         <= 1'b0;
    end else if (enable) begin
      horiz_sync_out <= hsync_c ? H_SYNC_POL : ~H_SYNC_POL;
      vert_sync_out  <= vsync_c ? V_SYNC_POL : ~V_SYNC_POL;
      video_on       <= h_vis_c && v_vis_c;
      pixel_column   <= (h_vis_c && v_vis_c) ? h_cnt : '0;
      pixel_row      <= (h_vis_c && v_vis_c) ? v_cnt : '0;
      line_start     <= h_zero_c;
      frame_start    <= h_zero_c && v_zero_c;
      vblank         <= ~v_vis_c;
    end else begin
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default VGA, a small active-high
// mode that makes whole frames cheap, and SVGA) share clock, reset and enable.
// Expected values come from a raster model that maps the count of enabled
// edges since reset to a linear pixel index and derives everything from it.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  always #5 clk = ~clk;

  logic       a_hs, a_vs, a_von, a_ls, a_fs, a_vb;
  logic [9:0] a_col, a_row;
  logic       b_hs, b_vs, b_von, b_ls, b_fs, b_vb;
  logic [5:0] b_col, b_row;
  logic       c_hs, c_vs, c_von, c_ls, c_fs, c_vb;
  logic [10:0] c_col, c_row;

  vga_timing_gen u_a (
    .pixel_clock_int(clk), .reset(reset), .enable(enable),
    .horiz_sync_out(a_hs), .vert_sync_out(a_vs), .video_on(a_von),
    .pixel_column(a_col), .pixel_row(a_row), .line_start(a_ls),
    .frame_start(a_fs), .vblank(a_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(6)
  ) u_b (
    .pixel_clock_int(clk), .reset(reset), .enable(enable),
    .horiz_sync_out(b_hs), .vert_sync_out(b_vs), .video_on(b_von),
    .pixel_column(b_col), .pixel_row(b_row), .line_start(b_ls),
    .frame_start(b_fs), .vblank(b_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .V_ACTIVE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(11)
  ) u_c (
    .pixel_clock_int(clk), .reset(reset), .enable(enable),
    .horiz_sync_out(c_hs), .vert_sync_out(c_vs), .video_on(c_von),
    .pixel_column(c_col), .pixel_row(c_row), .line_start(c_ls),
    .frame_start(c_fs), .vblank(c_vb)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;          // enabled edges since reset released
  bit last_en = 1'b0; // enable seen on the most recent edge

  typedef struct packed {
    logic hs, vs, von, ls, fs, vb;
    int   col;
    int   row;
  } exp_t;

  // Raster model: what the outputs must show after kk enabled edges.
  function automatic exp_t model(input int kk, input bit en,
                                 input int h_a, input int h_f, input int h_s, input int h_b,
                                 input int v_a, input int v_f, input int v_s, input int v_b,
                                 input bit hp, input bit vp);
    exp_t e;
    int ht, vt, p, c, r;
    ht = h_a + h_f + h_s + h_b;
    vt = v_a + v_f + v_s + v_b;
    e = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    if (kk > 0) begin
      p = (kk - 1) % (ht * vt);
      c = p % ht;
      r = p / ht;
      e.hs  = (c >= h_a + h_f && c < h_a + h_f + h_s) ? hp : ~hp;
      e.vs  = (r >= v_a + v_f && r < v_a + v_f + v_s) ? vp : ~vp;
      e.von = (c < h_a) && (r < v_a);
      e.col = e.von ? c : 0;
      e.row = e.von ? r : 0;
      e.ls  = en && (c == 0);
      e.fs  = en && (p == 0);
      e.vb  = (r >= v_a);
    end
    return e;
  endfunction

  function automatic exp_t exp_a();
    return model(k, last_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction
  function automatic exp_t exp_b();
    return model(k, last_en, 20, 3, 5, 4, 12, 2, 3, 2, 1'b1, 1'b1);
  endfunction
  function automatic exp_t exp_c();
    return model(k, last_en, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
  endfunction

  // One clock: drive enable, wait for the edge, settle 1 time unit.
  task automatic tick(input bit en);
    enable = en;
    @(posedge clk);
    if (en && !reset) k++;
    last_en = en;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    k = 0;
    last_en = 1'b0;
    tick(1'b1);
    tick(1'b1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    #1;
    checks++;
    if ({a_hs, a_vs, a_von, a_ls, a_fs, a_vb} !== 6'b110000) begin
      errors++; $display("FAIL reset_async_a flags got %b expected 110000", {a_hs, a_vs, a_von, a_ls, a_fs, a_vb});
    end
    tick(1'b1);
    tick(1'b1);
    checks++;
    if ({a_hs, a_vs, a_von, a_ls, a_fs, a_vb} !== 6'b110000) begin
      errors++; $display("FAIL reset_hold_a flags got %b expected 110000", {a_hs, a_vs, a_von, a_ls, a_fs, a_vb});
    end
    checks++;
    if ({b_hs, b_vs, b_von, b_ls, b_fs, b_vb} !== 6'b000000) begin
      errors++; $display("FAIL reset_hold_b flags got %b expected 000000", {b_hs, b_vs, b_von, b_ls, b_fs, b_vb});
    end
    checks++;
    if (a_col !== 10'd0 || a_row !== 10'd0 || c_col !== 11'd0 || c_row !== 11'd0) begin
      errors++; $display("FAIL reset_coords got a=%0d,%0d c=%0d,%0d expected 0", a_col, a_row, c_col, c_row);
    end
    k = 0;
    last_en = 1'b0;
    reset = 1'b0;
    tick(1'b1);
    checks++;
    if ({a_fs, a_ls, a_von} !== 3'b111 || a_col !== 10'd0 || a_row !== 10'd0) begin
      errors++; $display("FAIL first_pixel_a got fs=%b ls=%b von=%b col=%0d row=%0d expected 1 1 1 0 0", a_fs, a_ls, a_von, a_col, a_row);
    end
    checks++;
    if ({b_fs, b_ls, b_von, c_fs, c_ls, c_von} !== 6'b111111) begin
      errors++; $display("FAIL first_pixel_bc got %b expected 111111", {b_fs, b_ls, b_von, c_fs, c_ls, c_von});
    end
  endtask

  // Default VGA and SVGA line timing; continues straight on from reset release.
  task automatic test_default_line();
    exp_t ea, ec;
    int bad = 0;
    int a_von_cnt = 0, a_hs_cnt = 0, a_hs_first = -1;
    int c_hs_cnt = 0, c_hs_first = -1;
    int a_ls_idx[$];
    int c_ls_idx[$];
    for (int i = 0; i <= 2112; i++) begin
      ea = exp_a();
      ec = exp_c();
      if ({a_hs, a_von, a_ls, a_fs} !== {ea.hs, ea.von, ea.ls, ea.fs} || int'(a_col) != ea.col || int'(a_row) != ea.row) bad++;
      if ({c_hs, c_vs, c_von, c_ls, c_vb} !== {ec.hs, ec.vs, ec.von, ec.ls, ec.vb} || int'(c_col) != ec.col) bad++;
      if (i < 800) begin
        if (a_von) a_von_cnt++;
        if (!a_hs) begin a_hs_cnt++; if (a_hs_first < 0) a_hs_first = i; end
      end
      if (i < 1056 && c_hs) begin c_hs_cnt++; if (c_hs_first < 0) c_hs_first = i; end
      if (a_ls) a_ls_idx.push_back(i);
      if (c_ls) c_ls_idx.push_back(i);
      tick(1'b1);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL line_trace mismatches got %0d expected 0", bad); end
    checks++;
    if (a_von_cnt != 640) begin errors++; $display("FAIL a_video_on_width got %0d expected 640", a_von_cnt); end
    checks++;
    if (a_hs_cnt != 96 || a_hs_first != 656) begin
      errors++; $display("FAIL a_hsync got width %0d start %0d expected 96 656", a_hs_cnt, a_hs_first);
    end
    checks++;
    if (a_ls_idx.size() != 3 || a_ls_idx[1] - a_ls_idx[0] != 800 || a_ls_idx[2] - a_ls_idx[1] != 800) begin
      errors++; $display("FAIL a_line_period got %0d pulses expected 3 spaced 800", a_ls_idx.size());
    end
    checks++;
    if (c_hs_cnt != 128 || c_hs_first != 840) begin
      errors++; $display("FAIL c_hsync got width %0d start %0d expected 128 840", c_hs_cnt, c_hs_first);
    end
    checks++;
    if (c_ls_idx.size() != 3 || c_ls_idx[1] - c_ls_idx[0] != 1056 || c_ls_idx[2] - c_ls_idx[1] != 1056) begin
      errors++; $display("FAIL c_line_period got %0d pulses expected 3 spaced 1056", c_ls_idx.size());
    end
  endtask

  // Two full frames of the small mode, enable held high.
  task automatic test_full_frame();
    exp_t e;
    int bad = 0, vs_cnt = 0, vs_first = -1, vb_cnt = 0, max_row = 0;
    int fs_idx[$];
    do_reset();
    tick(1'b1);
    for (int i = 0; i <= 1216; i++) begin
      e = exp_b();
      if ({b_hs, b_vs, b_von, b_ls, b_fs, b_vb} !== {e.hs, e.vs, e.von, e.ls, e.fs, e.vb} ||
          int'(b_col) != e.col || int'(b_row) != e.row) bad++;
      if (i < 608) begin
        if (b_vs) begin vs_cnt++; if (vs_first < 0) vs_first = i; end
        if (b_vb) vb_cnt++;
      end
      if (b_fs) fs_idx.push_back(i);
      if (int'(b_row) > max_row) max_row = int'(b_row);
      tick(1'b1);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL frame_trace mismatches got %0d expected 0", bad); end
    checks++;
    if (vs_cnt != 96 || vs_first != 448) begin
      errors++; $display("FAIL b_vsync got width %0d start %0d expected 96 448", vs_cnt, vs_first);
    end
    checks++;
    if (vb_cnt != 224) begin errors++; $display("FAIL b_vblank_width got %0d expected 224", vb_cnt); end
    checks++;
    if (fs_idx.size() != 3 || fs_idx[1] - fs_idx[0] != 608 || fs_idx[2] - fs_idx[1] != 608) begin
      errors++; $display("FAIL b_frame_period got %0d pulses expected 3 spaced 608", fs_idx.size());
    end
    checks++;
    if (max_row != 11) begin errors++; $display("FAIL b_max_row got %0d expected 11", max_row); end
  endtask

  // Random enable: outputs must follow the model on every cycle, strobes only when enabled.
  task automatic test_random_enable();
    exp_t ea, eb;
    bit en;
    int bad = 0, low_pulse = 0, fs_seen = 0, guard = 0;
    do_reset();
    while (k < 1221 && guard < 6000) begin
      en = 1'($urandom_range(0, 1));
      tick(en);
      guard++;
      ea = exp_a();
      eb = exp_b();
      if ({b_hs, b_vs, b_von, b_ls, b_fs, b_vb} !== {eb.hs, eb.vs, eb.von, eb.ls, eb.fs, eb.vb} ||
          int'(b_col) != eb.col || int'(b_row) != eb.row) bad++;
      if ({a_hs, a_von, a_ls, a_fs} !== {ea.hs, ea.von, ea.ls, ea.fs} || int'(a_col) != ea.col) bad++;
      if (!en && (b_ls || b_fs || a_ls || a_fs)) low_pulse++;
      if (b_fs) fs_seen++;
    end
    checks++;
    if (k != 1221) begin errors++; $display("FAIL rand_progress got %0d enabled edges expected 1221", k); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_trace mismatches got %0d expected 0", bad); end
    checks++;
    if (low_pulse != 0) begin errors++; $display("FAIL rand_strobe_when_disabled got %0d expected 0", low_pulse); end
    checks++;
    if (fs_seen != 3) begin errors++; $display("FAIL rand_frame_starts got %0d expected 3", fs_seen); end
  endtask

  // Asynchronous reset in vertical blanking during hsync, then clean restart.
  task automatic test_reset_mid_blank();
    do_reset();
    while (k < 14 * 32 + 25 + 1) tick(1'b1);
    checks++;
    if ({b_hs, b_vs, b_von, b_vb} !== 4'b1101 || b_col !== 6'd0) begin
      errors++; $display("FAIL pre_reset_blank got %b col %0d expected 1101 col 0", {b_hs, b_vs, b_von, b_vb}, b_col);
    end
    #3;
    reset = 1'b1;
    k = 0;
    last_en = 1'b0;
    #1;
    checks++;
    if ({b_hs, b_vs, b_von, b_ls, b_fs, b_vb} !== 6'b000000 || b_col !== 6'd0 || b_row !== 6'd0) begin
      errors++; $display("FAIL async_reset_b got %b col %0d row %0d expected 000000 0 0", {b_hs, b_vs, b_von, b_ls, b_fs, b_vb}, b_col, b_row);
    end
    checks++;
    if ({a_hs, a_vs, a_von, a_vb} !== 4'b1100) begin
      errors++; $display("FAIL async_reset_a got %b expected 1100", {a_hs, a_vs, a_von, a_vb});
    end
    tick(1'b1);
    reset = 1'b0;
    tick(1'b1);
    checks++;
    if ({b_fs, b_ls, b_von, b_vb} !== 4'b1110 || b_col !== 6'd0 || b_row !== 6'd0) begin
      errors++; $display("FAIL restart_b got %b col %0d row %0d expected 1110 0 0", {b_fs, b_ls, b_von, b_vb}, b_col, b_row);
    end
    tick(1'b1);
    checks++;
    if ({b_fs, b_ls, b_von} !== 3'b001 || b_col !== 6'd1) begin
      errors++; $display("FAIL restart_second_b got %b col %0d expected 001 1", {b_fs, b_ls, b_von}, b_col);
    end
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    test_reset();
    test_default_line();
    test_full_frame();
    test_random_enable();
    test_reset_mid_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
